rr_fifo_scheduler: RTL and testbench
====================================

Name: rr_fifo_scheduler

Overview:
- Registered round-robin scheduler moving words from four input FIFOs to four output FIFOs through the shared mux/demux datapath.
- Each cycle it pops at most one non-empty input FIFO. It drives the mux select for the word returned one cycle later and pushes that word to the output FIFO named by its dest field.
- Fairness comes from a rotating priority pointer. A small FSM adds global backpressure, idle detection and a word counter for the status block.

Parameters:
- CNT_W, 8, width of the pushed-word counter (wraps modulo 2^CNT_W).
- RR_EN, 1, 1 = round-robin priority; 0 = fixed priority (input 0 highest).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low.
- empty_in  input  4  empty flags of input FIFOs 0..3.
- afull_out  input  4  almost-full flags of output FIFOs 0..3.
- dest  input  2  destination field of the mux output word; valid only in the cycle after a pop.
- pop  output  4  one-hot-or-zero pop to input FIFOs (combinational from state and inputs).
- push  output  4  one-hot-or-zero push to output FIFOs.
- mux_sel  output  2  registered select of the input mux; indexes the FIFO popped last cycle.
- state  output  2  FSM state: 00 RESET, 01 IDLE, 10 ACTIVE, 11 STALL.
- word_cnt  output  CNT_W  total words pushed since reset.
- idle  output  1  high when state is IDLE.

Behaviour:
- Reset (reset==0 sampled at posedge):
  - Registers: state=RESET, rr_ptr=0, valid_q=0, sel_q=0, word_cnt=0.
  - While reset is low, pop=0 and push=0 combinationally. A word in flight is dropped, not pushed.
- Gating terms:
  - stall = |afull_out. Backpressure is conservative because dest is unknown at pop time.
  - any_req = ~&empty_in.
- Grant (cycle N):
  - If reset==1 && !stall && any_req && state!=RESET: grant the first non-empty input found scanning from rr_ptr upward modulo 4. With RR_EN=0 the scan starts at 0.
  - pop = onehot(grant), otherwise pop = 0.
- Posedge after a grant:
  - valid_q=1, sel_q=grant index.
  - rr_ptr=(grant+1) mod 4; with RR_EN=0 rr_ptr stays 0.
  - Without a grant: valid_q=0; sel_q and rr_ptr hold.
- Push (cycle N+1):
  - push = valid_q ? onehot(dest) : 0.
  - mux_sel = sel_q.
  - Pop-to-push latency is exactly 1 cycle. Pop in N+1 may overlap push in N+1, giving a back-to-back throughput of 1 word/cycle.
- Stall arriving in N+1:
  - The in-flight word is still pushed; almost-full leaves headroom of at least 1.
  - Only new pops are blocked.
- word_cnt increments by 1 on every posedge where push!=0 and reset==1; it wraps from 2^CNT_W-1 to 0.
- FSM (registered, evaluated at posedge when reset==1):
  - RESET -> IDLE unconditionally (one cycle, no pops).
  - IDLE -> STALL if stall; else ACTIVE if any_req; else stay.
  - ACTIVE -> STALL if stall; else IDLE if !any_req && !valid_q; else stay.
  - STALL -> ACTIVE if !stall && (any_req || valid_q); IDLE if !stall && !any_req && !valid_q; else stay.
  - Pops are allowed in any state except RESET whenever the grant conditions hold. This keeps IDLE->ACTIVE free of a bubble; the state register is status only.
- Boundaries:
  - All empty: no pop; the pointer holds.
  - Single requester: granted every cycle.
  - Pointer wrap 3->0.
  - dest is ignored when valid_q==0.

Decomposition:
- Shared package: state encodings (ST_RESET, ST_IDLE, ST_ACTIVE, ST_STALL) and NUM_PORTS=4.
- One sub-module, rr_pick4: combinational 4-way rotating priority picker. Inputs are req[3:0] and ptr[1:0]; outputs are gnt_valid and gnt_idx[1:0].
- The FSM, pipeline registers and counter live in the top.

Test Plan:
- Reset checks:
  - Hold reset=0 for 3 cycles with empty_in=0000 -> pop=0000, push=0000, state=00, word_cnt=0.
  - First cycle after release -> state=00 then 01, no pop.
- Round-robin fairness: empty_in=0000, afull=0000, dest=2'b10 every cycle -> pop sequence 0001,0010,0100,1000,0001. Each push=0100 one cycle later, with mux_sel=0,1,2,3 lagging pop by 1. word_cnt=4 after 4 pushes.
- Sparse requests: empty_in=1010 constant -> pops alternate 0001,0100. Pointer wrap from 3 to 0 verified by starting with empty_in=0111.
- Backpressure: grant input 1 in cycle N, then afull_out=0100 in cycle N+1 -> push issued in N+1, no pop in N+1..while afull, state=11. On deassert, pops resume at input 2.
- Fixed priority (RR_EN=0), empty_in=0000 -> pop=0001 every cycle.
- Reset mid-flight: pop in N, reset=0 in N+1 -> push=0000, word_cnt=0, valid_q cleared.
- Counter wrap: CNT_W=3, 9 pushes -> word_cnt=1.

Source files
------------

// File: rtl/rr_fifo_scheduler_pkg.sv
// Shared definitions for the round-robin FIFO scheduler: port count,
// FSM state encodings and a one-hot helper.
package rr_fifo_scheduler_pkg;

  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_IDLE   = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_STALL  = 2'b11
  } state_e;

  function automatic logic [NUM_PORTS-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_fifo_scheduler_pick.sv
// Combinational 4-way rotating priority picker: the first set request found
// scanning upward from ptr (modulo 4) wins.
module rr_pick4
  import rr_fifo_scheduler_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           ptr,
  output logic                 gnt_valid,
  output logic [1:0]           gnt_idx
);

  logic [1:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    cand      = ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = ptr + 2'(i);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_fifo_scheduler.sv
// Moves words from four input FIFOs to four output FIFOs: pop in cycle N,
// push to the FIFO named by dest in cycle N+1, with a status FSM and counter.
module rr_fifo_scheduler
  import rr_fifo_scheduler_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter bit RR_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] empty_in,
  input  logic [NUM_PORTS-1:0] afull_out,
  input  logic [1:0]           dest,
  output logic [NUM_PORTS-1:0] pop,
  output logic [NUM_PORTS-1:0] push,
  output logic [1:0]           mux_sel,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     word_cnt,
  output logic                 idle
);

  state_e           state_q;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       stall, any_req, grant_en, gnt_valid;
  logic [1:0] gnt_idx, scan_ptr;

  // Backpressure is conservative: dest of the next word is unknown at pop time.
  assign stall    = |afull_out;
  assign any_req  = ~&empty_in;
  assign scan_ptr = RR_EN ? rr_ptr_q : 2'd0;

  rr_pick4 u_pick (
    .req       (~empty_in),
    .ptr       (scan_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign grant_en = reset && !stall && gnt_valid && (state_q != ST_RESET);
  assign pop      = grant_en ? onehot4(gnt_idx) : '0;
  assign push     = (reset && valid_q) ? onehot4(dest) : '0;

  always_comb begin
    valid_d  = grant_en;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (grant_en) begin
      sel_d    = gnt_idx;
      rr_ptr_d = RR_EN ? gnt_idx + 2'd1 : 2'd0;
    end
    if (push != '0) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      rr_ptr_q <= 2'd0;
      valid_q  <= 1'b0;
      sel_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      // State is status only; grants never wait on it except in RESET.
      case (state_q)
        ST_RESET:  state_q <= ST_IDLE;
        ST_IDLE: begin
          if (stall)        state_q <= ST_STALL;
          else if (any_req) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (stall)                      state_q <= ST_STALL;
          else if (!any_req && !valid_q)  state_q <= ST_IDLE;
        end
        ST_STALL: begin
          if (!stall) state_q <= (any_req || valid_q) ? ST_ACTIVE : ST_IDLE;
        end
        default:   state_q <= ST_RESET;
      endcase
    end
  end

  assign mux_sel  = sel_q;
  assign state    = state_q;
  assign word_cnt = cnt_q;
  assign idle     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_rr_fifo_scheduler.sv
// Directed bench for rr_fifo_scheduler: three instances (round-robin, fixed
// priority, 3-bit counter) share stimulus; pushes are checked from a queue.
module tb_rr_fifo_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] empty_in, afull_out;
  logic [1:0] dest;

  logic [3:0] pop, push, pop_f, push_f, pop_s, push_s;
  logic [1:0] mux_sel, mux_sel_f, mux_sel_s, state, state_f, state_s;
  logic [7:0] word_cnt, word_cnt_f;
  logic [2:0] word_cnt_s;
  logic       idle, idle_f, idle_s;

  rr_fifo_scheduler #(.CNT_W(8), .RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .empty_in(empty_in), .afull_out(afull_out),
    .dest(dest), .pop(pop), .push(push), .mux_sel(mux_sel), .state(state),
    .word_cnt(word_cnt), .idle(idle)
  );

  rr_fifo_scheduler #(.CNT_W(8), .RR_EN(1'b0)) dut_fixed (
    .clk(clk), .reset(reset), .empty_in(empty_in), .afull_out(afull_out),
    .dest(dest), .pop(pop_f), .push(push_f), .mux_sel(mux_sel_f), .state(state_f),
    .word_cnt(word_cnt_f), .idle(idle_f)
  );

  rr_fifo_scheduler #(.CNT_W(3), .RR_EN(1'b1)) dut_small (
    .clk(clk), .reset(reset), .empty_in(empty_in), .afull_out(afull_out),
    .dest(dest), .pop(pop_s), .push(push_s), .mux_sel(mux_sel_s), .state(state_s),
    .word_cnt(word_cnt_s), .idle(idle_s)
  );

  typedef struct packed {
    logic [1:0] idx_rr;
    logic [1:0] idx_fix;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // One clock cycle: drive, settle, compare, then advance past the edge.
  task automatic step(input logic rst, input logic [3:0] e, input logic [3:0] af,
                      input logic [1:0] d, input logic [3:0] exp_pop,
                      input logic [1:0] exp_st);
    logic [3:0] exp_pop_f, exp_push;
    sb_entry_t  ent;
    reset = rst; empty_in = e; afull_out = af; dest = d;
    #3;
    exp_pop_f = 4'b0000;
    if (exp_pop != 4'b0000)
      for (int i = 3; i >= 0; i--) if (!e[i]) exp_pop_f = 4'b0001 << i;
    exp_push = 4'b0000;
    if (!rst) begin
      sb_q.delete();
    end else if (sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      exp_push = 4'b0001 << d;
      chk("mux_sel", 32'(mux_sel), 32'(ent.idx_rr));
      chk("mux_sel_fixed", 32'(mux_sel_f), 32'(ent.idx_fix));
      chk("mux_sel_small", 32'(mux_sel_s), 32'(ent.idx_rr));
    end
    chk("pop", 32'(pop), 32'(exp_pop));
    chk("pop_fixed", 32'(pop_f), 32'(exp_pop_f));
    chk("pop_small", 32'(pop_s), 32'(exp_pop));
    chk("push", 32'(push), 32'(exp_push));
    chk("push_fixed", 32'(push_f), 32'(exp_push));
    chk("push_small", 32'(push_s), 32'(exp_push));
    chk("state", 32'(state), 32'(exp_st));
    chk("state_fixed", 32'(state_f), 32'(exp_st));
    chk("state_small", 32'(state_s), 32'(exp_st));
    chk("idle", 32'(idle), 32'(exp_st == 2'b01));
    chk("idle_fixed", 32'(idle_f), 32'(exp_st == 2'b01));
    chk("idle_small", 32'(idle_s), 32'(exp_st == 2'b01));
    chk("word_cnt", 32'(word_cnt), 32'(exp_cnt % 256));
    chk("word_cnt_fixed", 32'(word_cnt_f), 32'(exp_cnt % 256));
    chk("word_cnt_small", 32'(word_cnt_s), 32'(exp_cnt % 8));
    if (exp_pop != 4'b0000) begin
      ent.idx_rr  = idx_of(exp_pop);
      ent.idx_fix = idx_of(exp_pop_f);
      sb_q.push_back(ent);
    end
    @(posedge clk);
    #1;
    if (!rst)                         exp_cnt = 0;
    else if (exp_push != 4'b0000)     exp_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; empty_in = 4'b0000; afull_out = 4'b0000; dest = 2'd2;
    @(posedge clk);
    #1;
    // reset held low: nothing moves
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 4'b0000, 2'b00);
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 4'b0000, 2'b00);
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 4'b0000, 2'b00);
    // release: one cycle in RESET without pops
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b0000, 2'b00);
    // round-robin fairness, all inputs requesting
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b0001, 2'b01);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b0010, 2'b10);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b0100, 2'b10);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b1000, 2'b10);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b0001, 2'b10);
    // sparse requests: inputs 0 and 2 alternate
    step(1'b1, 4'b1010, 4'b0000, 2'd2, 4'b0100, 2'b10);
    step(1'b1, 4'b1010, 4'b0000, 2'd2, 4'b0001, 2'b10);
    step(1'b1, 4'b1010, 4'b0000, 2'd2, 4'b0100, 2'b10);
    step(1'b1, 4'b1010, 4'b0000, 2'd2, 4'b0001, 2'b10);
    // single requester on input 3, pointer wraps 3 -> 0
    step(1'b1, 4'b0111, 4'b0000, 2'd2, 4'b1000, 2'b10);
    step(1'b1, 4'b0111, 4'b0000, 2'd2, 4'b1000, 2'b10);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b0001, 2'b10);
    // backpressure after a grant of input 1
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b0010, 2'b10);
    step(1'b1, 4'b0000, 4'b0100, 2'd2, 4'b0000, 2'b10);
    step(1'b1, 4'b0000, 4'b0100, 2'd1, 4'b0000, 2'b11);
    step(1'b1, 4'b0000, 4'b0100, 2'd1, 4'b0000, 2'b11);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b0100, 2'b11);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b1000, 2'b10);
    // varying dest
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 4'b0001, 2'b10);
    step(1'b1, 4'b0000, 4'b0000, 2'd3, 4'b0010, 2'b10);
    // reset mid-flight drops the in-flight word
    step(1'b0, 4'b0000, 4'b0000, 2'd3, 4'b0000, 2'b10);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b0000, 2'b00);
    // all empty: idle, pointer holds at 0
    step(1'b1, 4'b1111, 4'b0000, 2'd2, 4'b0000, 2'b01);
    step(1'b1, 4'b1111, 4'b0000, 2'd2, 4'b0000, 2'b01);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 4'b0001, 2'b01);
    step(1'b1, 4'b1111, 4'b0000, 2'd1, 4'b0000, 2'b10);
    step(1'b1, 4'b1111, 4'b0000, 2'd1, 4'b0000, 2'b10);
    step(1'b1, 4'b1111, 4'b0000, 2'd1, 4'b0000, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
